// File: rtl/line_mem_burst_if.sv
// Request/response channel between a line requester (cache) and the line memory model.
interface line_mem_burst_if #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int ADDR_LEN      = 9,
   parameter int DATA_WIDTH    = 32
);
   localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;

   logic                            req_valid;
   logic                            req_ready;
   logic                            req_we;
   logic [ADDR_LEN-1:0]             req_addr;
   logic [LINE_SIZE*DATA_WIDTH-1:0] req_wdata;
   logic [LINE_SIZE-1:0]            req_wmask;
   logic                            resp_valid;
   logic                            resp_we;
   logic [LINE_SIZE*DATA_WIDTH-1:0] resp_rdata;
   logic                            busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wmask,
      input  req_ready, resp_valid, resp_we, resp_rdata, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wmask,
      output req_ready, resp_valid, resp_we, resp_rdata, busy
   );
endinterface

// File: rtl/line_mem_burst.sv
// Line-granular backing memory: one request moves a whole line after a fixed
// per-direction latency; words stream in/out during the last LINE_SIZE busy cycles.
module line_mem_burst #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int ADDR_LEN      = 9,
   parameter int DATA_WIDTH    = 32,
   parameter int RD_LAT        = 50,
   parameter int WR_LAT        = 50
) (
   input  logic            clk,
   input  logic            rst,
   line_mem_burst_if.slave bus
);
   localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
   localparam int LINE_W    = LINE_SIZE * DATA_WIDTH;
   localparam int WADDR_W   = ADDR_LEN + LINE_ADDR_LEN;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                  state;
   logic [31:0]             cnt;
   logic                    we_q;
   logic [ADDR_LEN-1:0]     addr_q;
   logic [LINE_W-1:0]       wdata_q;
   logic [LINE_SIZE-1:0]    wmask_q;
   logic [LINE_W-1:0]       shadow;
   logic [LINE_W-1:0]       rdata_q;
   logic                    ready_q;
   logic                    resp_valid_q;
   logic                    resp_we_q;
   logic                    busy_q;

   // Storage is deliberately outside the reset domain.
   logic [DATA_WIDTH-1:0]   mem [0:(1<<WADDR_W)-1];

   logic [31:0]             lat;
   logic                    xfer;
   logic                    last;
   logic [LINE_ADDR_LEN-1:0] off;
   logic [WADDR_W-1:0]      waddr;
   logic [DATA_WIDTH-1:0]   rword;
   logic [LINE_W-1:0]       shadow_nxt;

   always_comb begin
      lat        = we_q ? 32'(WR_LAT) : 32'(RD_LAT);
      xfer       = (state == BUSY) && (cnt >= lat - 32'(LINE_SIZE));
      last       = (state == BUSY) && (cnt == lat - 32'd1);
      off        = LINE_ADDR_LEN'(cnt - (lat - 32'(LINE_SIZE)));
      waddr      = {addr_q, off};
      rword      = mem[waddr];
      shadow_nxt = shadow;
      // The final word arrives on the same edge that publishes the line.
      if (xfer && !we_q)
         shadow_nxt[off*DATA_WIDTH +: DATA_WIDTH] = rword;
   end

   always_ff @(posedge clk)
      if (xfer && we_q && wmask_q[off])
         mem[waddr] <= wdata_q[off*DATA_WIDTH +: DATA_WIDTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         wmask_q      <= '0;
         shadow       <= '0;
         rdata_q      <= '0;
         ready_q      <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_we_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               we_q    <= bus.req_we;
               addr_q  <= bus.req_addr;
               wdata_q <= bus.req_wdata;
               wmask_q <= bus.req_wmask;
               cnt     <= '0;
               ready_q <= 1'b0;
               busy_q  <= 1'b1;
               state   <= BUSY;
            end
            BUSY: begin
               cnt    <= cnt + 32'd1;
               shadow <= shadow_nxt;
               if (last) begin
                  state        <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_we_q    <= we_q;
                  if (!we_q) rdata_q <= shadow_nxt;
               end
            end
            RESP: begin
               state        <= IDLE;
               resp_valid_q <= 1'b0;
               ready_q      <= 1'b1;
               busy_q       <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_we    = resp_we_q;
   assign bus.resp_rdata = rdata_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_line_mem_burst.sv
// Directed bench for line_mem_burst: 4-word lines, 16 lines, RD_LAT 8, WR_LAT 6.
module tb_line_mem_burst;
   localparam int LAL = 2, AL = 4, DW = 32, RDL = 8, WRL = 6, LW = 128;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   line_mem_burst_if #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL), .DATA_WIDTH(DW)) bus ();

   line_mem_burst #(
      .LINE_ADDR_LEN(LAL), .ADDR_LEN(AL), .DATA_WIDTH(DW), .RD_LAT(RDL), .WR_LAT(WRL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [LW-1:0] last_rdata;
   logic          last_we;
   int            last_lat;

   task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full transaction; request fields are scrambled right after acceptance.
   task automatic req(input logic we, input logic [AL-1:0] addr, input logic [LW-1:0] wd,
                      input logic [3:0] wm, input string tag);
      int n;
      bit got;
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
      bus.req_wdata = wd;   bus.req_wmask = wm;
      n = 0;
      while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
      chk($sformatf("%s ready", tag), bus.req_ready, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0; bus.req_addr = ~addr; bus.req_wdata = ~wd; bus.req_wmask = ~wm;
      got = 0; last_lat = -1;
      for (int k = 1; k <= 100 && !got; k++) begin
         @(negedge clk);
         if (k == 1) chk($sformatf("%s busy", tag), {bus.busy, bus.req_ready}, 2'b10);
         if (bus.resp_valid) begin
            got = 1; last_lat = k; last_we = bus.resp_we; last_rdata = bus.resp_rdata;
         end
      end
      chk($sformatf("%s latency", tag), last_lat, we ? WRL + 1 : RDL + 1);
      chk($sformatf("%s resp_we", tag), last_we, we);
      @(negedge clk);
      chk($sformatf("%s strobe", tag), bus.resp_valid, 0);
   endtask

   logic [LW-1:0] l3, lm, g7, p5, l0, l15;
   int nr, acc, first_acc, wresp, t1, t2, hold_bad;

   initial begin
      l3  = {32'h44, 32'h33, 32'h22, 32'h11};
      lm  = {32'hD, 32'hC, 32'hB, 32'hA};
      g7  = {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000};
      p5  = {32'h53, 32'h52, 32'h51, 32'h50};
      l0  = {32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001, 32'hC0DE_0000};
      l15 = {32'hF00D_0003, 32'hF00D_0002, 32'hF00D_0001, 32'hF00D_0000};
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
      bus.req_wdata = '0;   bus.req_wmask = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst outputs", {bus.req_ready, bus.resp_valid, bus.resp_we, bus.busy}, 4'b1000);
      chk("rst rdata", bus.resp_rdata, 0);
      rst = 1'b0;
      nr = 0;
      repeat (20) begin @(negedge clk); if (bus.resp_valid) nr++; end
      chk("idle no resp", nr, 0);
      chk("idle ready", bus.req_ready, 1);

      // full write then read
      req(1'b1, 4'd3, l3, 4'hF, "wr3");
      req(1'b0, 4'd3, '0, 4'h0, "rd3");
      chk("rd3 data", last_rdata, l3);

      // masked write leaves resp_rdata alone
      req(1'b1, 4'd3, lm, 4'b0101, "wrm");
      chk("wr keeps rdata", bus.resp_rdata, l3);
      req(1'b0, 4'd3, '0, 4'h0, "rdm");
      chk("rdm data", last_rdata, {32'h44, 32'hC, 32'h22, 32'hA});

      // inputs change after acceptance; valid held through BUSY
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd7;
      bus.req_wdata = g7;   bus.req_wmask = 4'hF;
      chk("g ready", bus.req_ready, 1);
      @(posedge clk); #1;
      bus.req_we = 1'b0; bus.req_addr = 4'd9; bus.req_wdata = ~g7;
      acc = 0; first_acc = -1; wresp = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (bus.resp_valid && wresp < 0) wresp = k;
         if (bus.req_valid && bus.req_ready) begin
            acc++;
            if (first_acc < 0) first_acc = k;
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
         end
      end
      bus.req_valid = 1'b0;
      chk("g wr latency", wresp, WRL + 1);
      chk("g 2nd accept time", first_acc, WRL + 2);
      chk("g accept once", acc, 1);
      req(1'b0, 4'd7, '0, 4'h0, "rd7");
      chk("rd7 data", last_rdata, g7);

      // reset in the middle of a write
      req(1'b1, 4'd5, p5, 4'hF, "wr5pre");
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd5;
      bus.req_wdata = {32'd4, 32'd3, 32'd2, 32'd1}; bus.req_wmask = 4'hF;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      nr = 0;
      repeat (5) begin @(posedge clk); #1; if (bus.resp_valid) nr++; end
      rst = 1'b1;
      @(negedge clk);
      chk("abort rdata cleared", bus.resp_rdata, 0);
      chk("abort outputs", {bus.req_ready, bus.resp_valid, bus.busy}, 3'b100);
      rst = 1'b0;
      repeat (10) begin @(negedge clk); if (bus.resp_valid) nr++; end
      chk("abort no resp", nr, 0);
      req(1'b0, 4'd5, '0, 4'h0, "rd5");
      chk("rd5 partial", last_rdata, {32'h53, 32'd3, 32'd2, 32'd1});

      // back-to-back reads of lines 0 and 15
      req(1'b1, 4'd0, l0, 4'hF, "wr0");
      req(1'b1, 4'd15, l15, 4'hF, "wr15");
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd0;
      @(posedge clk); #1;
      bus.req_addr = 4'd15;
      t1 = -1; t2 = -1; hold_bad = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.resp_valid) begin
            if (t1 < 0) begin t1 = cyc; chk("b2b rd0", bus.resp_rdata, l0); end
            else if (t2 < 0) begin t2 = cyc; chk("b2b rd15", bus.resp_rdata, l15); end
         end else if (t1 >= 0 && t2 < 0 && bus.resp_rdata !== l0) hold_bad++;
         if (bus.req_valid && bus.req_ready) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
         end
      end
      bus.req_valid = 1'b0;
      chk("b2b spacing", t2 - t1, 10);
      chk("b2b hold", hold_bad, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
